tmcuart_sched: RTL and testbench



---
 rtl/tmcuart_pkg.sv | 25 ++
 rtl/tmcuart_rr.sv | 32 +++
 rtl/tmcuart_sched.sv | 201 ++++++++++++++++++++
 tb/tb_tmcuart_sched.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tmcuart_pkg.sv
// TMC UART poll/host scheduler: shared status codes,
// FSM state encoding and arbitration constants.
package tmcuart_pkg;

   localparam int STATUS_BITS = 3;
   localparam int HOST_STREAK = 4;

   typedef enum logic [STATUS_BITS-1:0] {
      ST_OK          = 3'd0,
      ST_TIMEOUT     = 3'd1,
      ST_SYNC        = 3'd2,
      ST_MASTER_ADDR = 3'd3,
      ST_REGISTER    = 3'd4,
      ST_CRC         = 3'd5,
      ST_ABORT       = 3'd6
   } status_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_REPORT
   } state_e;

endpackage

// File: rtl/tmcuart_rr.sv
// Round-robin picker: first pending channel strictly
// after the last granted one, wrapping around.
module tmcuart_rr
   import tmcuart_pkg::*;
#(
   parameter int NUART = 4
) (
   input  logic [NUART-1:0]         pend_i,
   input  logic [$clog2(NUART)-1:0] last_i,
   output logic [$clog2(NUART)-1:0] gnt_o,
   output logic                     vld_o
);

   localparam int NB = $clog2(NUART);

   logic [NB-1:0] idx;

   // Scan farthest-first so the nearest hit is written last.
   always_comb begin
      gnt_o = '0;
      vld_o = 1'b0;
      idx   = '0;
      for (int i = NUART; i >= 1; i--) begin
         idx = NB'((int'(last_i) + i) % NUART);
         if (pend_i[idx]) begin
            gnt_o = idx;
            vld_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/tmcuart_sched.sv
// Arbitrates host requests and periodic status polls onto
// one TMC UART transaction engine, with a watchdog.
module tmcuart_sched
   import tmcuart_pkg::*;
#(
   parameter int         NUART          = 4,
   parameter int         POLL_CYCLES    = 48000,
   parameter logic [6:0] POLL_REG       = 7'h6F,
   parameter int         TIMEOUT_CYCLES = 262144
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     host_req,
   input  logic                     host_rdwr,
   input  logic [$clog2(NUART)-1:0] host_channel,
   input  logic [7:0]               host_slave,
   input  logic [6:0]               host_register,
   input  logic [31:0]              host_wdata,
   output logic                     host_ack,
   output logic                     host_done,
   output logic [STATUS_BITS-1:0]   host_status,
   output logic [31:0]              host_rdata,
   input  logic [NUART-1:0]         poll_enable,
   input  logic [7:0]               poll_slave,
   output logic                     poll_valid,
   output logic [$clog2(NUART)-1:0] poll_channel,
   output logic [STATUS_BITS-1:0]   poll_status,
   output logic [31:0]              poll_rdata,
   output logic                     eng_start,
   output logic                     eng_abort,
   output logic                     eng_rdwr,
   output logic [$clog2(NUART)-1:0] eng_channel,
   output logic [7:0]               eng_slave,
   output logic [6:0]               eng_register,
   output logic [31:0]              eng_wdata,
   input  logic                     eng_done,
   input  logic [STATUS_BITS-1:0]   eng_status,
   input  logic [31:0]              eng_rdata,
   input  logic                     shutdown
);

   localparam int NB = $clog2(NUART);
   localparam int CW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   state_e                  state_q;
   logic [NUART-1:0]        pend_q, pend_d;
   logic [NB-1:0]           last_q;
   logic [2:0]              streak_q;
   logic [CW-1:0]           tick_q;
   logic [TW-1:0]           wd_q;
   logic                    host_q;
   logic                    eng_start_q, eng_abort_q, eng_rdwr_q;
   logic [NB-1:0]           eng_channel_q;
   logic [7:0]              eng_slave_q;
   logic [6:0]              eng_register_q;
   logic [31:0]             eng_wdata_q;
   logic                    host_ack_q, host_done_q, poll_valid_q;
   logic [STATUS_BITS-1:0]  host_status_q, poll_status_q;
   logic [31:0]             host_rdata_q, poll_rdata_q;
   logic [NB-1:0]           poll_channel_q;

   logic                    tick, idle, poll_cand;
   logic                    grant_host, grant_poll;
   logic                    wd_exp, finish;
   logic [NB-1:0]           rr_gnt;
   logic                    rr_vld;
   logic [STATUS_BITS-1:0]  rep_status;
   logic [31:0]             rep_rdata;

   tmcuart_rr #(.NUART(NUART)) u_rr (
      .pend_i (pend_q),
      .last_i (last_q),
      .gnt_o  (rr_gnt),
      .vld_o  (rr_vld)
   );

   assign tick       = (tick_q == CW'(POLL_CYCLES - 1));
   assign idle       = (state_q == S_IDLE);
   assign poll_cand  = rr_vld & ~shutdown;
   assign grant_host = idle & host_req &
                       (~poll_cand | (streak_q < 3'(HOST_STREAK)));
   assign grant_poll = idle & poll_cand & ~grant_host;
   assign wd_exp     = (wd_q == TW'(TIMEOUT_CYCLES - 1));
   assign finish     = (state_q == S_WAIT) & (eng_done | wd_exp);
   assign rep_status = eng_done ? eng_status : ST_ABORT;
   assign rep_rdata  = (eng_done & eng_rdwr_q) ? eng_rdata : '0;

   // A tick in the grant cycle re-arms the channel: set beats clear.
   always_comb begin
      pend_d = pend_q;
      if (grant_poll) pend_d[rr_gnt] = 1'b0;
      if (tick) pend_d = pend_d | poll_enable;
      pend_d = pend_d & poll_enable;
      if (shutdown) pend_d = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= S_IDLE;
         pend_q         <= '0;
         last_q         <= NB'(NUART - 1);
         streak_q       <= '0;
         tick_q         <= '0;
         wd_q           <= '0;
         host_q         <= 1'b0;
         eng_start_q    <= 1'b0;
         eng_abort_q    <= 1'b0;
         eng_rdwr_q     <= 1'b0;
         eng_channel_q  <= '0;
         eng_slave_q    <= '0;
         eng_register_q <= '0;
         eng_wdata_q    <= '0;
         host_ack_q     <= 1'b0;
         host_done_q    <= 1'b0;
         host_status_q  <= '0;
         host_rdata_q   <= '0;
         poll_valid_q   <= 1'b0;
         poll_channel_q <= '0;
         poll_status_q  <= '0;
         poll_rdata_q   <= '0;
      end else begin
         tick_q       <= tick ? '0 : tick_q + CW'(1);
         pend_q       <= pend_d;
         eng_start_q  <= 1'b0;
         eng_abort_q  <= 1'b0;
         host_ack_q   <= 1'b0;
         host_done_q  <= 1'b0;
         poll_valid_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (grant_host) begin
                  state_q        <= S_ISSUE;
                  host_q         <= 1'b1;
                  eng_start_q    <= 1'b1;
                  host_ack_q     <= 1'b1;
                  eng_rdwr_q     <= host_rdwr;
                  eng_channel_q  <= host_channel;
                  eng_slave_q    <= host_slave;
                  eng_register_q <= host_register;
                  eng_wdata_q    <= host_wdata;
                  if (streak_q < 3'(HOST_STREAK))
                     streak_q <= streak_q + 3'd1;
               end else if (grant_poll) begin
                  state_q        <= S_ISSUE;
                  host_q         <= 1'b0;
                  eng_start_q    <= 1'b1;
                  eng_rdwr_q     <= 1'b1;
                  eng_channel_q  <= rr_gnt;
                  eng_slave_q    <= poll_slave;
                  eng_register_q <= POLL_REG;
                  eng_wdata_q    <= '0;
                  streak_q       <= '0;
                  last_q         <= rr_gnt;
               end
            end
            S_ISSUE: begin
               wd_q    <= TW'(1);
               state_q <= S_WAIT;
            end
            S_WAIT: begin
               if (finish) begin
                  state_q     <= S_REPORT;
                  eng_abort_q <= ~eng_done;
                  if (host_q) begin
                     host_done_q   <= 1'b1;
                     host_status_q <= rep_status;
                     host_rdata_q  <= rep_rdata;
                  end else begin
                     poll_valid_q   <= 1'b1;
                     poll_channel_q <= eng_channel_q;
                     poll_status_q  <= rep_status;
                     poll_rdata_q   <= rep_rdata;
                  end
               end else begin
                  wd_q <= wd_q + TW'(1);
               end
            end
            S_REPORT: state_q <= S_IDLE;
            default:  state_q <= S_IDLE;
         endcase
      end
   end

   assign host_ack     = host_ack_q;
   assign host_done    = host_done_q;
   assign host_status  = host_status_q;
   assign host_rdata   = host_rdata_q;
   assign poll_valid   = poll_valid_q;
   assign poll_channel = poll_channel_q;
   assign poll_status  = poll_status_q;
   assign poll_rdata   = poll_rdata_q;
   assign eng_start    = eng_start_q;
   assign eng_abort    = eng_abort_q;
   assign eng_rdwr     = eng_rdwr_q;
   assign eng_channel  = eng_channel_q;
   assign eng_slave    = eng_slave_q;
   assign eng_register = eng_register_q;
   assign eng_wdata    = eng_wdata_q;

endmodule

// File: tb/tb_tmcuart_sched.sv
// Scoreboard bench for tmcuart_sched: expected grants and
// results are queued by the stimulus/engine model.
module tb_tmcuart_sched;

   localparam int NUART = 4;
   localparam int NB    = 2;
   localparam int POLL  = 100;
   localparam int TMO   = 150;
   localparam logic [6:0] PREG = 7'h6F;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic host_req = 1'b0, host_rdwr = 1'b0;
   logic [NB-1:0] host_channel = '0;
   logic [7:0] host_slave = '0;
   logic [6:0] host_register = '0;
   logic [31:0] host_wdata = '0;
   logic host_ack, host_done;
   logic [2:0] host_status;
   logic [31:0] host_rdata;
   logic [NUART-1:0] poll_enable = '0;
   logic [7:0] poll_slave = '0;
   logic poll_valid;
   logic [NB-1:0] poll_channel;
   logic [2:0] poll_status;
   logic [31:0] poll_rdata;
   logic eng_start, eng_abort, eng_rdwr;
   logic [NB-1:0] eng_channel;
   logic [7:0] eng_slave;
   logic [6:0] eng_register;
   logic [31:0] eng_wdata;
   logic eng_done = 1'b0;
   logic [2:0] eng_status = '0;
   logic [31:0] eng_rdata = '0;
   logic shutdown = 1'b0;

   always #5 clk = ~clk;

   tmcuart_sched #(
      .NUART(NUART), .POLL_CYCLES(POLL),
      .POLL_REG(PREG), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk), .rst(rst),
      .host_req(host_req), .host_rdwr(host_rdwr),
      .host_channel(host_channel), .host_slave(host_slave),
      .host_register(host_register), .host_wdata(host_wdata),
      .host_ack(host_ack), .host_done(host_done),
      .host_status(host_status), .host_rdata(host_rdata),
      .poll_enable(poll_enable), .poll_slave(poll_slave),
      .poll_valid(poll_valid), .poll_channel(poll_channel),
      .poll_status(poll_status), .poll_rdata(poll_rdata),
      .eng_start(eng_start), .eng_abort(eng_abort),
      .eng_rdwr(eng_rdwr), .eng_channel(eng_channel),
      .eng_slave(eng_slave), .eng_register(eng_register),
      .eng_wdata(eng_wdata), .eng_done(eng_done),
      .eng_status(eng_status), .eng_rdata(eng_rdata),
      .shutdown(shutdown)
   );

   typedef struct {
      bit poll; bit rd; logic [NB-1:0] ch;
      logic [7:0] sl; logic [6:0] rg; logic [31:0] wd;
   } grant_t;
   typedef struct {
      bit poll; logic [NB-1:0] ch; logic [2:0] st; logic [31:0] rd;
   } rsp_t;

   grant_t gq[$];
   rsp_t   rq[$];
   int checks = 0, passes = 0;
   int cyc = 0, starts = 0, rsps = 0, pulses = 0;
   int last_start = -100, start_cyc = 0, eng_cnt = 0, eng_delay = 20;
   bit eng_never = 1'b0, force_ok = 1'b0;
   logic [2:0] pst;
   logic [31:0] prd;
   grant_t eg;
   rsp_t er, mr;

   logic [126:0] outs;
   assign outs = {host_ack, host_done, host_status, host_rdata,
                  poll_valid, poll_channel, poll_status, poll_rdata,
                  eng_start, eng_abort, eng_rdwr, eng_channel,
                  eng_slave, eng_register, eng_wdata};

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic fail(input string nm);
      checks++;
      $display("FAIL %s: got no/unexpected event, expected the other", nm);
   endtask

   function automatic grant_t pg(input int ch);
      grant_t g;
      g.poll = 1'b1; g.rd = 1'b1; g.ch = NB'(ch);
      g.sl = poll_slave; g.rg = PREG; g.wd = '0;
      return g;
   endfunction

   // Engine model and grant checker.
   initial forever begin
      @(negedge clk);
      cyc++;
      eng_done = 1'b0;
      if (eng_cnt > 0) begin
         eng_cnt--;
         if (eng_cnt == 0) begin
            eng_done = 1'b1; eng_status = pst; eng_rdata = prd;
         end
      end
      if (!rst && eng_abort)
         chk("abort_cycle", 64'(cyc - start_cyc), 64'(TMO));
      if (!rst && eng_start) begin
         chk("start_gap", 64'((cyc - last_start) >= 3), 64'd1);
         last_start = cyc; start_cyc = cyc; starts++;
         if (gq.size() == 0) fail("unexpected_start");
         else begin
            eg = gq.pop_front();
            chk("grant_fields",
                {eng_rdwr, eng_channel, eng_slave, eng_register,
                 eng_wdata, host_ack},
                {eg.rd, eg.ch, eg.sl, eg.rg, eg.wd, !eg.poll});
            prd = $urandom;
            pst = force_ok ? 3'd0 : 3'($urandom_range(0, 5));
            er.poll = eg.poll; er.ch = eg.ch;
            if (eng_never) begin
               er.st = 3'd6; er.rd = '0;
            end else begin
               eng_cnt = eng_delay;
               er.st = pst; er.rd = eg.rd ? prd : '0;
            end
            rq.push_back(er);
         end
      end
   end

   // Result monitor.
   initial forever begin
      @(negedge clk);
      if (!rst && (host_done || poll_valid)) begin
         pulses++;
         if (rq.size() == 0) fail("unexpected_done");
         else begin
            mr = rq.pop_front();
            rsps++;
            chk("rsp_kind", {host_done, poll_valid}, {!mr.poll, mr.poll});
            if (mr.poll)
               chk("poll_rsp", {poll_channel, poll_status, poll_rdata},
                   {mr.ch, mr.st, mr.rd});
            else
               chk("host_rsp", {host_status, host_rdata}, {mr.st, mr.rd});
         end
      end
   end

   task automatic host_issue(input bit rd, input bit keep);
      grant_t g;
      int k;
      host_rdwr     = rd;
      host_channel  = NB'($urandom_range(0, NUART - 1));
      host_slave    = 8'($urandom_range(0, 255));
      host_register = 7'($urandom_range(0, 127));
      host_wdata    = $urandom;
      g.poll = 1'b0; g.rd = rd; g.ch = host_channel;
      g.sl = host_slave; g.rg = host_register; g.wd = host_wdata;
      gq.push_back(g);
      host_req = 1'b1;
      k = 0;
      do begin @(negedge clk); k++; end while (!host_ack && k < 400);
      if (!host_ack) fail("host_ack_timeout");
      if (!keep) host_req = 1'b0;
   endtask

   task automatic wait_rsps(input int n, input int budget, input string nm);
      int k = 0;
      while (rsps < n && k < budget) begin @(negedge clk); k++; end
      if (rsps < n) fail(nm);
   endtask

   task automatic wait_starts(input int n, input int budget);
      int k = 0;
      while (starts < n && k < budget) begin @(negedge clk); k++; end
      if (starts < n) fail("start_timeout");
   endtask

   initial begin
      int base, k;
      repeat (3) @(negedge clk);
      chk("reset_outputs", 64'($countones(outs)), 64'd0);
      rst = 1'b0;

      // Two ticks with mask 0101: ch0 then ch2 each time.
      poll_slave = 8'($urandom_range(0, 255));
      gq.push_back(pg(0)); gq.push_back(pg(2));
      gq.push_back(pg(0)); gq.push_back(pg(2));
      poll_enable = 4'b0101;
      wait_rsps(4, 450, "tick_polls_timeout");
      poll_enable = '0;
      repeat (10) @(negedge clk);

      // Long ch0 poll sees a tick in WAIT; host held: H,H,H,H,P,H.
      poll_slave = 8'($urandom_range(0, 255));
      base = rsps;
      gq.push_back(pg(0));
      eng_delay = 110;
      poll_enable = 4'b0001;
      wait_starts(starts + 1, 150);
      eng_delay = 20;
      for (int i = 1; i <= 5; i++) begin
         if (i == 5) gq.push_back(pg(0));
         host_issue(1'($urandom_range(0, 1)), i < 5);
      end
      poll_enable = '0;
      wait_rsps(base + 7, 200, "streak_timeout");
      repeat (30) @(negedge clk);

      // Engine silent: watchdog abort with status 6.
      poll_slave = 8'($urandom_range(0, 255));
      base = rsps;
      gq.push_back(pg(0));
      eng_never = 1'b1;
      poll_enable = 4'b0001;
      k = 0;
      do begin @(negedge clk); k++; end while (!eng_abort && k < 400);
      poll_enable = '0;
      if (!eng_abort) fail("abort_timeout");
      wait_rsps(base + 1, 5, "abort_rsp_timeout");
      eng_never = 1'b0;
      repeat (10) @(negedge clk);

      // Shutdown with two channels pending and a host write queued.
      base = rsps;
      eng_delay = 110;
      poll_enable = 4'b0011;
      host_issue(1'b1, 1'b0);
      repeat (102) @(negedge clk);
      shutdown = 1'b1;
      force_ok = 1'b1;
      eng_delay = 20;
      host_issue(1'b0, 1'b0);
      wait_rsps(base + 2, 100, "shutdown_timeout");
      repeat (30) @(negedge clk);
      poll_enable = '0;
      shutdown = 1'b0;
      force_ok = 1'b0;
      chk("grant_queue_empty", 64'(gq.size()), 64'd0);
      chk("rsp_queue_empty", 64'(rq.size()), 64'd0);

      // Reset in WAIT discards the transaction.
      host_issue(1'b1, 1'b0);
      repeat (6) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("reset_in_wait", 64'($countones(outs)), 64'd0);
      @(negedge clk);
      gq.delete();
      rq.delete();
      @(negedge clk);
      rst = 1'b0;
      base = pulses;
      repeat (40) @(negedge clk);
      chk("no_done_after_reset", 64'(pulses - base), 64'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
